// File: rtl/line_clear_engine.sv
// Line-clear engine: scans a locked playfield bottom-up, removes full rows by
// shifting the rows above down one at a time, and accumulates a saturating score.
module line_clear_engine #(
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 10,
  parameter int unsigned SCORE_W   = 32,
  parameter int unsigned PTS_SCALE = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [0:ROWS*COLS-1]       field_in,
  input  logic                       clear_score,
  output logic                       busy,
  output logic                       done,
  output logic [0:ROWS*COLS-1]       field_out,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  output logic [SCORE_W-1:0]         score
);

  localparam int unsigned Cells  = ROWS * COLS;
  localparam int unsigned CntW   = $clog2(ROWS + 1);
  localparam int unsigned PtrW   = $clog2(ROWS);
  localparam int unsigned MaxInc = PTS_SCALE * ROWS * ROWS;
  localparam int unsigned IncW   = $clog2(MaxInc + 1);
  // One spare bit above the wider of score and increment so the sum never wraps.
  localparam int unsigned SumW   = ((SCORE_W > IncW) ? SCORE_W : IncW) + 1;

  typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [0:Cells-1]   work_q, work_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [0:Cells-1]   fout_q, fout_d;
  logic [CntW-1:0]    lines_q, lines_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               row_full;
  logic [0:Cells-1]   row_sel;
  logic [0:Cells-1]   keep_mask;
  logic [SumW-1:0]    inc;
  logic [SumW-1:0]    sum;
  logic [SumW-1:0]    score_max;

  // Row under the pointer, and the mask of rows below it that a shift leaves alone.
  always_comb begin
    row_sel   = work_q << (32'(ptr_q) * COLS);
    row_full  = &row_sel[0:COLS-1];
    keep_mask = {Cells{1'b1}} >> ((32'(ptr_q) + 32'd1) * COLS);
  end

  // Saturating score increment of PTS_SCALE * count^2.
  always_comb begin
    score_max = SumW'({SCORE_W{1'b1}});
    inc       = SumW'(PTS_SCALE) * SumW'(cnt_q) * SumW'(cnt_q);
    sum       = SumW'(score_q) + inc;
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fout_d  = fout_q;
    lines_d = lines_q;
    score_d = score_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = field_in;
          ptr_d   = PtrW'(ROWS - 1);
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (row_full) begin
          state_d = StShift;
        end else if (ptr_q == '0) begin
          fout_d  = work_q;
          lines_d = cnt_q;
          score_d = (sum > score_max) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
          state_d = StDone;
        end else begin
          ptr_d = ptr_q - PtrW'(1);
        end
      end
      StShift: begin
        // Rows 0..ptr move down one row; row 0 fills with zeros.
        work_d  = (work_q & keep_mask) | ((work_q >> COLS) & ~keep_mask);
        cnt_d   = cnt_q + CntW'(1);
        state_d = StScan;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Clearing wins over a coincident accumulation.
    if (clear_score) score_d = '0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      work_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fout_q  <= '0;
      lines_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fout_q  <= fout_d;
      lines_q <= lines_d;
      score_q <= score_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign field_out     = fout_q;
  assign lines_cleared = lines_q;
  assign score         = score_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Randomised scoreboard bench for line_clear_engine, plus a narrow-score instance
// for saturation and clear priority.
module tb_line_clear_engine;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int N    = ROWS * COLS;

  logic           clock = 1'b0;
  logic           resetn;
  logic           start, clear_score;
  logic [0:N-1]   field_in;
  logic           busy, done;
  logic [0:N-1]   field_out;
  logic [3:0]     lines_cleared;
  logic [31:0]    score;

  logic           start8, clear8;
  logic [0:N-1]   field8;
  logic           busy8, done8;
  logic [0:N-1]   fout8;
  logic [3:0]     lines8;
  logic [7:0]     score8;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  longint model_score = 0;

  typedef struct {
    logic [0:N-1] fout;
    int           lines;
    longint       score;
    int           start_cyc;
  } exp_t;
  exp_t sb[$];

  line_clear_engine u_dut (
    .clock(clock), .resetn(resetn), .start(start), .field_in(field_in),
    .clear_score(clear_score), .busy(busy), .done(done), .field_out(field_out),
    .lines_cleared(lines_cleared), .score(score)
  );

  line_clear_engine #(.SCORE_W(8)) u_dut8 (
    .clock(clock), .resetn(resetn), .start(start8), .field_in(field8),
    .clear_score(clear8), .busy(busy8), .done(done8), .field_out(fout8),
    .lines_cleared(lines8), .score(score8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: drop every full row, stack the survivors at the bottom.
  function automatic logic [0:N-1] clear_model(input logic [0:N-1] f, output int n);
    logic [0:N-1] res;
    int dst;
    bit full;
    res = '0;
    dst = ROWS - 1;
    n   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) full &= f[r*COLS+c];
      if (full) n++;
      else begin
        for (int c = 0; c < COLS; c++) res[dst*COLS+c] = f[r*COLS+c];
        dst--;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse of the main instance must match the oldest expectation.
  always @(negedge clock) begin
    if (resetn && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        if (field_out !== e.fout) begin
          miscompares++;
          $display("FAIL field_out: got %h, expected %h", field_out, e.fout);
        end
        check("lines_cleared", longint'(lines_cleared), longint'(e.lines));
        check("score", longint'(score), e.score);
        check("latency", longint'(cyc - e.start_cyc), longint'(ROWS + 2 * e.lines));
      end
    end
  end

  task automatic run_op(input logic [0:N-1] f, input bit clr, input bit mid_start);
    exp_t e;
    int n;
    bit seen;
    @(negedge clock);
    start       = 1'b1;
    field_in    = f;
    clear_score = clr;
    e.fout      = clear_model(f, n);
    e.lines     = n;
    if (clr) model_score = 0;
    else begin
      model_score += longint'(n * n);
      if (model_score > 64'hFFFF_FFFF) model_score = 64'hFFFF_FFFF;
    end
    e.score     = model_score;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mid_start && i == 4) begin
        start    = 1'b1;
        field_in = {N{1'b1}};
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    start       = 1'b0;
    clear_score = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done, expected one within 100 cycles");
      void'(sb.pop_front());
    end
    // A stray accepted start would surface as an unexpected done here.
    repeat (ROWS + 3) @(negedge clock);
  endtask

  function automatic logic [0:N-1] rand_field();
    logic [0:N-1] f;
    for (int r = 0; r < ROWS; r++) begin
      bit full;
      full = ($urandom_range(2) == 0);
      for (int c = 0; c < COLS; c++) f[r*COLS+c] = full ? 1'b1 : 1'($urandom_range(1));
    end
    return f;
  endfunction

  initial begin
    logic [0:N-1] f;
    longint exp8 [4];
    bit seen;
    resetn = 1'b0; start = 1'b0; clear_score = 1'b0; field_in = '0;
    start8 = 1'b0; clear8 = 1'b0; field8 = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_score", longint'(score), 0);
    check("rst_lines", longint'(lines_cleared), 0);
    check("rst_field_out", longint'(field_out != '0), 0);
    resetn = 1'b1;
    @(negedge clock);

    // Directed cases.
    run_op('0, 1'b0, 1'b0);
    f = '0;
    for (int c = 0; c < COLS; c++) f[90+c] = 1'b1;
    f[85] = 1'b1;
    run_op(f, 1'b0, 1'b0);
    f = '0;
    for (int c = 0; c < COLS; c++) begin
      f[70+c] = 1'b1;
      f[90+c] = 1'b1;
    end
    f[80] = 1'b1;
    run_op(f, 1'b0, 1'b0);
    run_op({N{1'b1}}, 1'b0, 1'b1);

    // Randomised operations.
    for (int k = 0; k < 25; k++) begin
      f = ($urandom_range(9) == 0) ? {N{1'b1}} : rand_field();
      run_op(f, ($urandom_range(7) == 0), ($urandom_range(3) == 0));
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clock);
    start = 1'b1; field_in = {N{1'b1}};
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_score", longint'(score), 0);
    check("midrst_lines", longint'(lines_cleared), 0);
    check("midrst_field_out", longint'(field_out != '0), 0);
    @(negedge clock);
    resetn = 1'b1;
    model_score = 0;
    run_op({N{1'b1}}, 1'b0, 1'b0);
    run_op(rand_field(), 1'b0, 1'b0);

    // Narrow score: saturation, then clear coinciding with completion.
    exp8[0] = 100; exp8[1] = 200; exp8[2] = 255; exp8[3] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      start8 = 1'b1; field8 = {N{1'b1}}; clear8 = (k == 3);
      @(negedge clock);
      start8 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (done8) begin
          seen = 1'b1;
          break;
        end
        @(negedge clock);
      end
      clear8 = 1'b0;
      if (!seen) begin
        vectors++;
        miscompares++;
        $display("FAIL done8_timeout: got no done, expected one within 100 cycles");
      end else begin
        check("score8", longint'(score8), exp8[k]);
        check("lines8", longint'(lines8), 10);
        check("field8_out", longint'(fout8 != '0), 0);
      end
      @(negedge clock);
    end

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 SHALL take parameter COLS, default 10, columns per playfield row (>=1).
REQ-002 SHALL take parameter ROWS, default 10, playfield rows (>=2); row 0 is the top row.
REQ-003 SHALL take parameter SCORE_W, default 32, score accumulator width.
REQ-004 SHALL take parameter PTS_SCALE, default 1, points multiplier.
REQ-005 SHALL have port clock, input, 1, the single clock; all state is on its rising edge.
REQ-006 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port start, input, 1, request to process field_in; sampled only in IDLE.
REQ-008 SHALL have port field_in, input, [0:ROWS*COLS-1], locked playfield; bit r*COLS+c = row r, column c, 1 = occupied.
REQ-009 SHALL have port clear_score, input, 1, synchronous score clear.
REQ-010 SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port field_out, output, [0:ROWS*COLS-1], registered field after clearing.
REQ-013 SHALL have port lines_cleared, output, $clog2(ROWS+1), full rows removed by the last operation.
REQ-014 SHALL have port score, output, SCORE_W, saturating running score.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, SHIFT, DONE.
REQ-016 In IDLE with start=1, SHALL copy field_in into the work register, set row pointer = ROWS-1, set count = 0, and go to SCAN.
REQ-017 In SCAN, if the pointed row is all ones, SHALL go to SHIFT.
REQ-018 In SCAN, if the pointed row is not full and pointer = 0, SHALL go to DONE; otherwise it SHALL decrement the pointer and stay in SCAN.
REQ-019 In SHIFT, SHALL copy each row r (1..pointer) from row r-1, zero row 0, increment count, keep the pointer unchanged, and return to SCAN (the same row is rechecked).
REQ-020 On the edge entering DONE, SHALL load field_out from the work register and lines_cleared from count, and add PTS_SCALE*count*count to score, saturating at 2^SCORE_W-1.
REQ-021 In DONE, SHALL assert done for exactly one cycle, then go to IDLE; field_out, lines_cleared and score are already valid in that cycle.
REQ-022 Latency: with start accepted at edge 0 and n full rows, done SHALL be high in cycle ROWS+2n+1.
REQ-023 start while busy SHALL be ignored (not queued); start in the DONE cycle SHALL be ignored.
REQ-024 clear_score SHALL zero score in any state; it takes priority over a coincident DONE accumulation.
REQ-025 field_out and lines_cleared SHALL hold their values until the next DONE entry.
REQ-026 An all-ones field SHALL yield n = ROWS and field_out = 0.
REQ-027 Internal arithmetic for the increment SHALL be wide enough that PTS_SCALE*ROWS*ROWS does not wrap before saturation.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, busy=0, done=0, field_out=0, lines_cleared=0, score=0, pointer=0, count=0, and work register=0, including in the middle of SCAN or SHIFT.
REQ-029 After resetn rises, the first start SHALL be accepted normally.

Verification (defaults unless stated)
REQ-030 Empty field, start -> done in cycle 11; lines_cleared=0; score=0; field_out=0.
REQ-031 Row 9 full plus bit 85 -> done in cycle 13; field_out has only bit 95 set; lines_cleared=1; score=1.
REQ-032 Rows 7 and 9 full plus bit 80 -> done in cycle 15; field_out has only bit 90 set; lines_cleared=2; score=4.
REQ-033 All-ones field -> done in cycle 31; field_out=0; lines_cleared=10; score=100; a start pulsed mid-operation is ignored (exactly one done).
REQ-034 resetn low during SCAN of an all-ones field -> busy, done, score and field_out are 0 without a clock edge; a fresh start completes normally.
REQ-035 SCORE_W=8, three all-ones operations -> score 100, 200, 255 (saturated); clear_score coincident with the next DONE -> score=0.
